// File: rtl/wired_inst_queue_pkg.sv
// Shared frontend/backend instruction types and small helpers used by the
// instruction queue.
package wired_inst_queue_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd;
  } pipeline_ctrl_pack_t;

  function automatic logic [1:0] popcount2(input logic [1:0] m);
    return {1'b0, m[0]} + {1'b0, m[1]};
  endfunction

endpackage

// File: rtl/wired_inst_queue.sv
// Dual-issue circular instruction queue between decode and the backend.
// Accepts compacted 0-2 instruction packets and emits up to two in order.
module wired_inst_queue
  import wired_inst_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [1:0]                in_mask_i,
  input  pipeline_ctrl_pack_t [1:0] in_pkg_i,
  output logic                      pkg_valid_o,
  input  logic                      pkg_ready_i,
  output logic [1:0]                pkg_mask_o,
  output pipeline_ctrl_pack_t [1:0] pkg_o,
  output logic [PTR_W:0]            count_o
);

  // Handshake: a transfer happens on a rising edge where valid & ready are
  // both high and flush_i is low; valid never waits on ready.
  localparam logic [PTR_W:0] READY_MAX = (PTR_W + 1)'(DEPTH - 2);

  pipeline_ctrl_pack_t mem_q [DEPTH];
  pipeline_ctrl_pack_t mem_d [DEPTH];
  logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d;
  logic [PTR_W-1:0]    head_p1, tail_p1;
  logic [PTR_W:0]      cnt_q, cnt_d;
  logic [1:0]          n_in, n_out;
  logic                enq_fire, deq_fire;
  pipeline_ctrl_pack_t wr_pkg0;

  always_comb begin
    head_p1     = head_q + PTR_W'(1);
    tail_p1     = tail_q + PTR_W'(1);
    in_ready_o  = (cnt_q <= READY_MAX);
    pkg_valid_o = (cnt_q != '0);
    if (cnt_q >= (PTR_W + 1)'(2)) pkg_mask_o = 2'b11;
    else if (cnt_q == (PTR_W + 1)'(1)) pkg_mask_o = 2'b01;
    else pkg_mask_o = 2'b00;
    pkg_o[0] = mem_q[head_q];
    pkg_o[1] = mem_q[head_p1];
    count_o  = cnt_q;
  end

  always_comb begin
    n_in     = popcount2(in_mask_i);
    n_out    = popcount2(pkg_mask_o);
    enq_fire = in_valid_i & in_ready_o & ~flush_i;
    deq_fire = pkg_valid_o & pkg_ready_i & ~flush_i;
    // Squeeze out an invalid slot 0 so the first valid instruction lands at tail.
    wr_pkg0  = in_mask_i[0] ? in_pkg_i[0] : in_pkg_i[1];
    mem_d    = mem_q;
    head_d   = head_q;
    tail_d   = tail_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else begin
      if (enq_fire) begin
        if (n_in != 2'd0) mem_d[tail_q] = wr_pkg0;
        if (n_in == 2'd2) mem_d[tail_p1] = in_pkg_i[1];
        tail_d = tail_q + PTR_W'(n_in);
      end
      if (deq_fire) head_d = head_q + PTR_W'(n_out);
      cnt_d = cnt_q + (enq_fire ? (PTR_W + 1)'(n_in) : '0)
                    - (deq_fire ? (PTR_W + 1)'(n_out) : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n)
    cnt_q <= (PTR_W + 1)'(DEPTH));
  a_no_enq_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(enq_fire && !in_ready_o));
  a_mask_legal: assert property (@(posedge clk) disable iff (!rst_n)
    pkg_mask_o != 2'b10);

endmodule

// File: tb/tb_wired_inst_queue.sv
// Directed, table-driven bench for wired_inst_queue with an in-order
// scoreboard on the backend side.
module tb_wired_inst_queue;
  import wired_inst_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam int PTR_W = $clog2(DEPTH);

  logic                      clk;
  logic                      rst_n;
  logic                      flush_i;
  logic                      in_valid_i;
  logic                      in_ready_o;
  logic [1:0]                in_mask_i;
  pipeline_ctrl_pack_t [1:0] in_pkg_i;
  logic                      pkg_valid_o;
  logic                      pkg_ready_i;
  logic [1:0]                pkg_mask_o;
  pipeline_ctrl_pack_t [1:0] pkg_o;
  logic [PTR_W:0]            count_o;

  wired_inst_queue #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_mask_i   (in_mask_i),
    .in_pkg_i    (in_pkg_i),
    .pkg_valid_o (pkg_valid_o),
    .pkg_ready_i (pkg_ready_i),
    .pkg_mask_o  (pkg_mask_o),
    .pkg_o       (pkg_o),
    .count_o     (count_o)
  );

  // Clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic        iv;
    logic [1:0]  im;
    logic [31:0] p0;
    logic [31:0] p1;
    logic        rdy;
    int          e_cnt;
    logic        e_v;
    logic [1:0]  e_m;
    logic        e_rdy;
    logic [31:0] e_p0;
    logic [31:0] e_p1;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic vec_t mk(logic fl, logic iv, logic [1:0] im, logic [31:0] p0,
                              logic [31:0] p1, logic rdy, int e_cnt, logic e_v,
                              logic [1:0] e_m, logic e_rdy, logic [31:0] e_p0,
                              logic [31:0] e_p1);
    vec_t v;
    v.fl = fl; v.iv = iv; v.im = im; v.p0 = p0; v.p1 = p1; v.rdy = rdy;
    v.e_cnt = e_cnt; v.e_v = e_v; v.e_m = e_m; v.e_rdy = e_rdy;
    v.e_p0 = e_p0; v.e_p1 = e_p1;
    return v;
  endfunction

  function automatic pipeline_ctrl_pack_t mk_pkg(logic [31:0] pc);
    pipeline_ctrl_pack_t p;
    p.pc   = pc;
    p.inst = ~pc;
    p.rd   = pc[6:2];
    return p;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  // Scoreboard: every accepted backend packet must match the oldest entries.
  always @(negedge clk) begin
    if (rst_n && pkg_valid_o && pkg_ready_i && !flush_i) begin
      if (exp_q.size() == 0) chk("sb_empty", 32'(exp_q.size()), 32'd1);
      else chk("sb_slot0_pc", pkg_o[0].pc, exp_q.pop_front());
      if (pkg_mask_o == 2'b11) begin
        if (exp_q.size() == 0) chk("sb_empty", 32'(exp_q.size()), 32'd1);
        else chk("sb_slot1_pc", pkg_o[1].pc, exp_q.pop_front());
      end
    end
  end

  // Driver: apply one cycle of inputs, then check state after the edge.
  task automatic step(input vec_t v, input int idx);
    flush_i     = v.fl;
    in_valid_i  = v.iv;
    in_mask_i   = v.im;
    in_pkg_i[0] = mk_pkg(v.p0);
    in_pkg_i[1] = mk_pkg(v.p1);
    pkg_ready_i = v.rdy;
    if (v.fl) exp_q.delete();
    else if (v.iv && (DEPTH - exp_q.size()) >= 2) begin
      if (v.im[0]) exp_q.push_back(v.p0);
      if (v.im[1]) exp_q.push_back(v.p1);
    end
    @(posedge clk);
    #1;
    chk($sformatf("v%0d_cnt", idx), 32'(count_o), 32'(v.e_cnt));
    chk($sformatf("v%0d_valid", idx), 32'(pkg_valid_o), 32'(v.e_v));
    chk($sformatf("v%0d_mask", idx), 32'(pkg_mask_o), 32'(v.e_m));
    chk($sformatf("v%0d_ready", idx), 32'(in_ready_o), 32'(v.e_rdy));
    if (v.e_m != 2'b00) chk($sformatf("v%0d_pc0", idx), pkg_o[0].pc, v.e_p0);
    if (v.e_m == 2'b11) chk($sformatf("v%0d_pc1", idx), pkg_o[1].pc, v.e_p1);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_valid"}, 32'(pkg_valid_o), 32'd0);
    chk({tag, "_mask"}, 32'(pkg_mask_o), 32'd0);
    chk({tag, "_cnt"}, 32'(count_o), 32'd0);
    chk({tag, "_ready"}, 32'(in_ready_o), 32'd1);
  endtask

  initial begin
    rst_n       = 1'b0;
    flush_i     = 1'b0;
    in_valid_i  = 1'b0;
    in_mask_i   = 2'b00;
    in_pkg_i    = '0;
    pkg_ready_i = 1'b0;

    //        fl  iv  im     p0            p1            rdy cnt v  m      rdy e_p0          e_p1
    // fill while stalled, then drain
    tbl.push_back(mk(0, 1, 2'b11, 32'h100,      32'h104,      0, 2, 1, 2'b11, 1, 32'h100,      32'h104));
    tbl.push_back(mk(0, 1, 2'b11, 32'h108,      32'h10c,      0, 4, 1, 2'b11, 1, 32'h100,      32'h104));
    tbl.push_back(mk(0, 1, 2'b11, 32'h110,      32'h114,      0, 6, 1, 2'b11, 1, 32'h100,      32'h104));
    tbl.push_back(mk(0, 1, 2'b01, 32'h118,      32'h0,        0, 7, 1, 2'b11, 0, 32'h100,      32'h104));
    tbl.push_back(mk(0, 1, 2'b11, 32'h11c,      32'h120,      0, 7, 1, 2'b11, 0, 32'h100,      32'h104));
    tbl.push_back(mk(0, 0, 2'b00, 32'h0,        32'h0,        1, 5, 1, 2'b11, 1, 32'h108,      32'h10c));
    tbl.push_back(mk(0, 0, 2'b00, 32'h0,        32'h0,        1, 3, 1, 2'b11, 1, 32'h110,      32'h114));
    tbl.push_back(mk(0, 0, 2'b00, 32'h0,        32'h0,        1, 1, 1, 2'b01, 1, 32'h118,      32'h0));
    tbl.push_back(mk(0, 0, 2'b00, 32'h0,        32'h0,        1, 0, 0, 2'b00, 1, 32'h0,        32'h0));
    // head now 7: pair straddles the wrap point
    tbl.push_back(mk(0, 1, 2'b11, 32'h200,      32'h204,      0, 2, 1, 2'b11, 1, 32'h200,      32'h204));
    tbl.push_back(mk(0, 0, 2'b00, 32'h0,        32'h0,        1, 0, 0, 2'b00, 1, 32'h0,        32'h0));
    // compaction of mask 10 then 01, then odd drain 3->1->0
    tbl.push_back(mk(0, 1, 2'b10, 32'hbad,      32'h1c000004, 0, 1, 1, 2'b01, 1, 32'h1c000004, 32'h0));
    tbl.push_back(mk(0, 1, 2'b01, 32'h1c000008, 32'hbad,      0, 2, 1, 2'b11, 1, 32'h1c000004, 32'h1c000008));
    tbl.push_back(mk(0, 1, 2'b01, 32'h300,      32'hbad,      0, 3, 1, 2'b11, 1, 32'h1c000004, 32'h1c000008));
    tbl.push_back(mk(0, 0, 2'b00, 32'h0,        32'h0,        1, 1, 1, 2'b01, 1, 32'h300,      32'h0));
    tbl.push_back(mk(0, 0, 2'b00, 32'h0,        32'h0,        1, 0, 0, 2'b00, 1, 32'h0,        32'h0));
    // empty-mask packet is a no-op
    tbl.push_back(mk(0, 1, 2'b00, 32'hbad,      32'hbad,      0, 0, 0, 2'b00, 1, 32'h0,        32'h0));
    // simultaneous enqueue/dequeue, then mask widening while stalled
    tbl.push_back(mk(0, 1, 2'b11, 32'h400,      32'h404,      0, 2, 1, 2'b11, 1, 32'h400,      32'h404));
    tbl.push_back(mk(0, 1, 2'b01, 32'h408,      32'h0,        1, 1, 1, 2'b01, 1, 32'h408,      32'h0));
    tbl.push_back(mk(0, 1, 2'b01, 32'h40c,      32'h0,        0, 2, 1, 2'b11, 1, 32'h408,      32'h40c));
    tbl.push_back(mk(0, 1, 2'b11, 32'h410,      32'h414,      0, 4, 1, 2'b11, 1, 32'h408,      32'h40c));
    tbl.push_back(mk(0, 1, 2'b01, 32'h418,      32'h0,        0, 5, 1, 2'b11, 1, 32'h408,      32'h40c));
    // flush beats enqueue and dequeue in the same cycle
    tbl.push_back(mk(1, 1, 2'b11, 32'h500,      32'h504,      1, 0, 0, 2'b00, 1, 32'h0,        32'h0));
    tbl.push_back(mk(0, 1, 2'b01, 32'h600,      32'h0,        0, 1, 1, 2'b01, 1, 32'h600,      32'h0));
    tbl.push_back(mk(0, 1, 2'b01, 32'h610,      32'h0,        0, 2, 1, 2'b11, 1, 32'h600,      32'h610));
    tbl.push_back(mk(0, 1, 2'b11, 32'h620,      32'h624,      0, 4, 1, 2'b11, 1, 32'h600,      32'h610));

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_reset_state("reset");

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

    // Reset mid-operation with 4 entries buffered
    in_valid_i  = 1'b0;
    pkg_ready_i = 1'b0;
    flush_i     = 1'b0;
    rst_n       = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_reset_state("midrst");

    step(mk(0, 1, 2'b01, 32'h700, 32'h0, 0, 1, 1, 2'b01, 1, 32'h700, 32'h0), 100);
    step(mk(0, 0, 2'b00, 32'h0,   32'h0, 1, 0, 0, 2'b00, 1, 32'h0,   32'h0), 101);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
